// File: rtl/div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// div_sequencer_pkg : shared state encoding and iteration count for the divider
// Revision: 1.0
// ============================================================================
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int DIV_CYCLES = 32;

endpackage
`default_nettype wire

// File: rtl/div_sequencer_if.sv
`default_nettype none
// ============================================================================
// div_sequencer_if : E-stage divide request/result bundle (pipeline <-> divider)
// Revision: 1.0
// ============================================================================
interface div_sequencer_if #(
  parameter int DATA_W = 32
);

  logic              start;
  logic              is_signed;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              cancel;
  logic              hold;
  logic              stall_req_div;
  logic              result_valid;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor, cancel, hold,
    input  stall_req_div, result_valid, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor, cancel, hold,
    output stall_req_div, result_valid, quotient, remainder
  );

endinterface
`default_nettype wire

// File: rtl/div_sequencer_radix2_step.sv
`default_nettype none
// ============================================================================
// div_radix2_step : one combinational restoring-division iteration
// Revision: 1.0
// ============================================================================
module div_radix2_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] rem_sh;
  logic            borrow;

  always_comb begin
    // Shifted remainder needs one extra bit; the restored result always fits DATA_W.
    rem_sh = {rem_i, quo_i[DATA_W-1]};
    borrow = (rem_sh < {1'b0, dvs_i});
    quo_o  = {quo_i[DATA_W-2:0], ~borrow};
    rem_o  = borrow ? rem_sh[DATA_W-1:0] : (rem_sh[DATA_W-1:0] - dvs_i);
  end

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// div_sequencer : multi-cycle radix-2 restoring DIV/DIVU with E-stage stall FSM
// Option macro  : DIV_ZERO_FAST_EN (divide-by-zero finishes in one cycle)
// Revision: 1.0
// ============================================================================
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DATA_W = DIV_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  div_sequencer_if.slave  bus
);

  localparam int               CNT_W     = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              dz_q, dz_d;

  logic              a_sign, b_sign, b_zero, fast_zero;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W-1:0] step_rem, step_quo;

  assign a_sign = bus.is_signed & bus.dividend[DATA_W-1];
  assign b_sign = bus.is_signed & bus.divisor[DATA_W-1];
  assign a_mag  = a_sign ? -bus.dividend : bus.dividend;
  assign b_mag  = b_sign ? -bus.divisor  : bus.divisor;
  assign b_zero = (bus.divisor == '0);

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = b_zero;
`else
  assign fast_zero = 1'b0;
`endif

  div_radix2_step #(.DATA_W(DATA_W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (bus.start) state_d = fast_zero ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (cnt_q == LAST_STEP) state_d = DIV_DONE;
      DIV_DONE: if (!bus.hold) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (bus.cancel) state_d = DIV_IDLE;
  end

  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          dvs_d   = b_mag;
          q_neg_d = a_sign ^ b_sign;
          r_neg_d = a_sign;
          dz_d    = b_zero;
          cnt_d   = '0;
          if (fast_zero) begin
            quo_d = '1;
            rem_d = bus.dividend;
          end else begin
            quo_d = a_mag;
            rem_d = '0;
          end
        end
      end
      DIV_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          // Div-by-zero keeps all-ones; remainder fixup restores the raw dividend.
          quo_d = dz_q ? '1 : (q_neg_q ? -step_quo : step_quo);
          rem_d = r_neg_q ? -step_rem : step_rem;
        end else begin
          quo_d = step_quo;
          rem_d = step_rem;
        end
      end
      default: ;
    endcase
    if (bus.cancel) begin
      cnt_d = '0;
      rem_d = '0;
      quo_d = '0;
    end
  end

  always_comb begin
    bus.stall_req_div = ((bus.start && (state_q == DIV_IDLE)) || (state_q == DIV_BUSY))
                        && !bus.cancel;
    bus.result_valid  = (state_q == DIV_DONE) && !bus.cancel;
    bus.quotient      = quo_q;
    bus.remainder     = rem_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// tb_div_sequencer : directed vector table plus multi-cycle corner sequences
// Revision: 1.0
// ============================================================================
module tb_div_sequencer;

  localparam int DATA_W = 32;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  div_sequencer_if #(.DATA_W(DATA_W)) bus ();

  div_sequencer #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input vec_t v, input int exp_lat);
    int lat;
    bit busy_ok;
    bus.is_signed = v.sgn;
    bus.dividend  = v.a;
    bus.divisor   = v.b;
    bus.start     = 1'b1;
    #1;
    check("stall_cycle0", 32'(bus.stall_req_div), 32'd1);
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.result_valid && lat < 40) begin
      tick();
      lat++;
      if (!bus.result_valid && !bus.stall_req_div) busy_ok = 1'b0;
    end
    check("stall_busy", 32'(busy_ok), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("quotient", bus.quotient, v.q);
    check("remainder", bus.remainder, v.r);
    check("stall_done", 32'(bus.stall_req_div), 32'd0);
    bus.start = 1'b0;
    tick();
    check("valid_idle", 32'(bus.result_valid), 32'd0);
  endtask

  vec_t vecs[11];
  vec_t v93;
  vec_t v1007;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[7]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
    vecs[8]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0};
    vecs[9]  = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE};
    vecs[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    v93   = '{1'b0, 32'd9,   32'd3, 32'd3,  32'd0};
    v1007 = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.cancel    = 1'b0;
    bus.hold      = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    check("rst_stall", 32'(bus.stall_req_div), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i], (vecs[i].b == 32'd0) ? ZERO_LAT : 33);
    end

    // Cancel mid-BUSY, then a fresh operation.
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    bus.start     = 1'b1;
    repeat (10) tick();
    bus.cancel = 1'b1;
    #1;
    check("cancel_stall", 32'(bus.stall_req_div), 32'd0);
    check("cancel_valid", 32'(bus.result_valid), 32'd0);
    tick();
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    #1;
    check("cancel_idle_stall", 32'(bus.stall_req_div), 32'd0);
    check("cancel_cleared_q", bus.quotient, 32'd0);
    tick();
    run_op(v93, 33);

    // Cancel beats a simultaneous start in IDLE.
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    bus.cancel   = 1'b1;
    #1;
    check("cancel_start_stall", 32'(bus.stall_req_div), 32'd0);
    tick();
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    #1;
    check("cancel_start_not_busy", 32'(bus.stall_req_div), 32'd0);
    tick();

    // Hold in DONE for three cycles with start still asserted.
    bus.hold  = 1'b1;
    bus.start = 1'b1;
    repeat (33) tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        #1;
      end
      check("hold_valid", 32'(bus.result_valid), 32'd1);
      check("hold_quotient", bus.quotient, 32'd14);
      check("hold_remainder", bus.remainder, 32'd2);
      check("hold_stall", 32'(bus.stall_req_div), 32'd0);
      if (k < 3) tick();
    end
    tick();
    check("hold_release_valid", 32'(bus.result_valid), 32'd0);
    check("hold_release_stall", 32'(bus.stall_req_div), 32'd0);
    tick();

    // Cancel while in DONE drops result_valid that cycle.
    bus.hold  = 1'b1;
    bus.start = 1'b1;
    repeat (33) tick();
    check("done_before_cancel", 32'(bus.result_valid), 32'd1);
    bus.cancel = 1'b1;
    #1;
    check("done_cancel_valid", 32'(bus.result_valid), 32'd0);
    tick();
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    bus.hold   = 1'b0;
    #1;
    check("done_cancel_idle", 32'(bus.result_valid), 32'd0);
    check("done_cancel_q", bus.quotient, 32'd0);
    tick();

    // Reset in the middle of BUSY.
    bus.start = 1'b1;
    repeat (16) tick();
    check("pre_rst_busy", 32'(bus.stall_req_div), 32'd1);
    rst       = 1'b1;
    bus.start = 1'b0;
    tick();
    check("midrst_valid", 32'(bus.result_valid), 32'd0);
    check("midrst_quotient", bus.quotient, 32'd0);
    check("midrst_remainder", bus.remainder, 32'd0);
    check("midrst_stall", 32'(bus.stall_req_div), 32'd0);
    rst = 1'b0;
    tick();
    run_op(v1007, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
